usb_dpdm_tx: RTL

- Parametrised USB low/full-speed line transmitter.
- Takes the NRZI-encoded bit stream from the NRZI stage over a valid/ready/last handshake and buffers it in an internal FIFO.
- Generates the SYNC field itself, then serialises the packet onto DP/DM with an explicit output enable, then appends a configurable EOP.
- Sits between the NRZI encoder and the bus pad drivers, and reports completion and underflow to the protocol FSM.

---
 rtl/usb_dpdm_tx.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/usb_dpdm_tx.sv
// usb_dpdm_tx: USB LS/FS line transmitter. Buffers NRZI bits, emits SYNC, data and EOP on DP/DM.
// Optional feature: define USB_DPDM_TX_IDLE_DRIVE_EN to drive J with oe=1 while idle.
module usb_dpdm_tx #(
  parameter int SYNC_BITS      = 8,
  parameter int FIFO_DEPTH     = 16,
  parameter int EOP_SE0_CYCLES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic in_bit,
  input  logic in_valid,
  input  logic in_last,
  output logic in_ready,
  output logic dp,
  output logic dm,
  output logic oe,
  output logic busy,
  output logic out_done,
  output logic underflow
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = (SYNC_BITS > 1) ? $clog2(SYNC_BITS) : 1;
  localparam int EW = (EOP_SE0_CYCLES > 1) ? $clog2(EOP_SE0_CYCLES) : 1;
  localparam logic [PW-1:0] PTR_LAST  = PW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(FIFO_DEPTH);
  localparam logic [SW-1:0] SYNC_LAST = SW'(SYNC_BITS - 1);
  localparam logic [EW-1:0] EOP_LAST  = EW'(EOP_SE0_CYCLES - 1);

`ifdef USB_DPDM_TX_IDLE_DRIVE_EN
  localparam logic IDLE_OE = 1'b1;
  localparam logic IDLE_DP = 1'b1;
`else
  localparam logic IDLE_OE = 1'b0;
  localparam logic IDLE_DP = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_DATA,
    S_EOP_SE0,
    S_EOP_J
  } state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] sync_cnt_q, sync_cnt_d;
  logic [EW-1:0] eop_cnt_q, eop_cnt_d;
  logic          aborted_q, aborted_d;
  logic          last_seen_q, last_seen_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          dp_q, dp_d;
  logic          dm_q, dm_d;
  logic          oe_q, oe_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          unf_q, unf_d;

  logic          mem_bit  [FIFO_DEPTH];
  logic          mem_last [FIFO_DEPTH];

  logic          push, pop, fifo_empty, fifo_full;
  logic          next_head, sync_is_k;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  // Handshake and FIFO bookkeeping; a pop in DATA frees a slot in the same cycle.
  always_comb begin
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == CNT_FULL);
    pop        = (state_q == S_DATA) && !fifo_empty;
    in_ready   = 1'b0;
    case (state_q)
      S_IDLE:         in_ready = 1'b1;
      S_SYNC, S_DATA: in_ready = (!fifo_full || pop) && !last_seen_q;
      default:        in_ready = 1'b0;
    endcase
    push     = in_valid && in_ready;
    count_d  = count_q + CW'(push) - CW'(pop);
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    // Outputs are registered one cycle ahead, so look at the head as it will be after this edge.
    if (push && (count_q == CW'(pop))) begin
      next_head = in_bit;
    end else begin
      next_head = mem_bit[rd_ptr_d];
    end
  end

  always_comb begin
    state_d     = state_q;
    sync_cnt_d  = sync_cnt_q;
    eop_cnt_d   = eop_cnt_q;
    aborted_d   = aborted_q;
    last_seen_d = last_seen_q || (push && in_last);
    case (state_q)
      S_IDLE: begin
        if (push) begin
          state_d    = S_SYNC;
          sync_cnt_d = '0;
        end
      end
      S_SYNC: begin
        if (sync_cnt_q == SYNC_LAST) begin
          state_d = S_DATA;
        end else begin
          sync_cnt_d = sync_cnt_q + SW'(1);
        end
      end
      S_DATA: begin
        if (fifo_empty) begin
          state_d   = S_EOP_SE0;
          eop_cnt_d = '0;
          aborted_d = 1'b1;
        end else if (mem_last[rd_ptr_q]) begin
          state_d   = S_EOP_SE0;
          eop_cnt_d = '0;
        end
      end
      S_EOP_SE0: begin
        if (eop_cnt_q == EOP_LAST) begin
          state_d = S_EOP_J;
        end else begin
          eop_cnt_d = eop_cnt_q + EW'(1);
        end
      end
      S_EOP_J: begin
        state_d     = S_IDLE;
        aborted_d   = 1'b0;
        last_seen_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    sync_is_k = !sync_cnt_d[0] || (sync_cnt_d == SYNC_LAST);
    oe_d      = 1'b1;
    dp_d      = 1'b0;
    dm_d      = 1'b0;
    done_d    = 1'b0;
    unf_d     = 1'b0;
    busy_d    = (state_d != S_IDLE);
    case (state_d)
      S_IDLE: begin
        oe_d = IDLE_OE;
        dp_d = IDLE_DP;
      end
      S_SYNC: begin
        dp_d = !sync_is_k;
        dm_d = sync_is_k;
      end
      S_DATA: begin
        if (count_d == '0) begin
          unf_d = 1'b1;
        end else begin
          dp_d = next_head;
          dm_d = !next_head;
        end
      end
      S_EOP_J: begin
        dp_d   = 1'b1;
        done_d = !aborted_d;
      end
      default: begin
        dp_d = 1'b0;
        dm_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (push && !reset) begin
      mem_bit[wr_ptr_q]  <= in_bit;
      mem_last[wr_ptr_q] <= in_last;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      sync_cnt_q  <= '0;
      eop_cnt_q   <= '0;
      aborted_q   <= 1'b0;
      last_seen_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      dp_q        <= IDLE_DP;
      dm_q        <= 1'b0;
      oe_q        <= IDLE_OE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_cnt_q  <= sync_cnt_d;
      eop_cnt_q   <= eop_cnt_d;
      aborted_q   <= aborted_d;
      last_seen_q <= last_seen_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      dp_q        <= dp_d;
      dm_q        <= dm_d;
      oe_q        <= oe_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      unf_q       <= unf_d;
    end
  end

  assign dp        = dp_q;
  assign dm        = dm_q;
  assign oe        = oe_q;
  assign busy      = busy_q;
  assign out_done  = done_q;
  assign underflow = unf_q;

endmodule
